dff_bank_arbiter: RTL and testbench
===================================

# dff_bank_arbiter

Two-requester arbiter and sequencer for a shared WIDTH-bit register bank built from D flip-flops with active-low asynchronous preset and clear. It grants the bank to one requester at a time using round-robin arbitration. It then runs the granted operation (load, clear, preset, toggle) by driving each flip-flop's d, pre and clr pins, and holds the bank value between operations by feeding q back to d.

## Interface
Parameters:
- WIDTH, 8, bank width in bits
- PULSE, 2, cycles that bank_clr/bank_pre stay asserted for a clear/preset op (≥1)

Ports:
- clk  in  1  rising-edge clock, shared with the bank flip-flops
- clr  in  1  asynchronous active-low reset
- req0, req1  in  1  operation requests
- op0, op1  in  2  opcode per requester: 00 load, 01 clear, 10 preset, 11 toggle
- data0, data1  in  WIDTH  load data per requester
- gnt0, gnt1  out  1  grant, registered, one-hot or zero
- done  out  1  one-cycle completion pulse
- busy  out  1  high in any state other than IDLE
- bank_q  in  WIDTH  current bank q outputs
- bank_d  out  WIDTH  bank d inputs
- bank_pre  out  WIDTH  active-low preset to every bank bit, registered
- bank_clr  out  WIDTH  active-low clear to every bank bit, registered

## Operation
- States: IDLE, EXEC, DONE.
- IDLE: samples req0/req1 only here. On any request, the next state is EXEC.
  - On entering EXEC: gnt of the winner goes to 1, and its op and data are latched into internal registers.
- Arbitration when both requests are high: grant the requester not served last (pointer `last`). Reset value of `last` = 1, so req0 wins the first tie. `last` updates on every grant.
- A single request is always granted, regardless of `last`.
- EXEC by latched op:
  - load: bank_d = latched data for 1 cycle.
  - clear: bank_clr = all 0 for PULSE cycles; bank_d = bank_q.
  - preset: bank_pre = all 0 for PULSE cycles; bank_d = bank_q.
  - toggle: bank_d = ~bank_q for 1 cycle.
- DONE: done = 1 and the grant stays high. bank_pre and bank_clr are all 1 and bank_d = bank_q. The next state is IDLE.
- Outside EXEC, bank_d = bank_q (hold).
- bank_pre and bank_clr are never both asserted.
- Requests, op and data arriving while busy are ignored. A requester must drop req by the edge that ends DONE; if req is still high in IDLE, it counts as a new request.
- A PULSE counter sized to hold PULSE counts down in EXEC for clear/preset.

## Timing
- Reset (clr low, takes effect immediately):
  - state = IDLE, gnt0 = gnt1 = 0, done = 0, busy = 0, `last` = 1, counter = 0.
  - bank_pre = all 1, bank_clr = all 0, so the bank clears together with the controller.
- At the first clk edge after clr rises, bank_clr goes to all 1.
- Edge E0 is the edge where IDLE sees a request.
- Load and toggle:
  - EXEC covers cycle E0..E1; the bank captures the new value at E1.
  - DONE covers E1..E2; done is high in this cycle.
  - IDLE is reached at E2, so request-to-done latency = 1 cycle.
- Clear and preset:
  - EXEC lasts PULSE cycles, with the pin asserted throughout.
  - DONE lasts 1 cycle, so done rises PULSE cycles after E0.
- busy and gnt are high from E0 to the end of DONE.
- Reset asserted mid-operation aborts the operation at once: no done, and the grant drops immediately. A clear pulse becomes the reset clear; a preset pulse is released.
- Back-to-back requests: minimum spacing between successive grants is 3 cycles for load/toggle (EXEC, DONE, IDLE).

## Configuration
- DFFCTL_TOGGLE_EN defined: op 11 performs toggle as described above.
- DFFCTL_TOGGLE_EN undefined: op 11 is a no-op.
  - It is still granted and follows load timing (EXEC 1 cycle, then DONE).
  - bank_d = bank_q throughout, so the bank is unchanged.

## Test plan
1. Reset, then req0 load data0=8'hA5 → gnt0 high for 2 cycles, done at cycle 2, bank_q=8'hA5, busy back to 0 at cycle 3.
2. With bank=8'hA5 and PULSE=2, req1 clear → bank_clr=8'h00 for exactly 2 cycles, bank_q=8'h00, done 1 cycle later; bank_pre stays 8'hFF.
3. req0 and req1 high together in IDLE three times, with req1 held and req0 re-raised → grant order gnt0, gnt1, gnt0.
4. Toggle on bank=8'h0F → 8'hF0 with DFFCTL_TOGGLE_EN defined; bank stays 8'h0F with it undefined, with done at the same cycle in both builds.
5. Preset in progress (bank_pre=00, first cycle) then clr low → bank_pre=FF and bank_clr=00 immediately, bank=8'h00, no done pulse, gnt=0.
6. req0 held high through DONE → re-granted in the cycle after IDLE; req1 raised while busy is ignored until the next IDLE.

Source files
------------

// File: rtl/dff_bank_arbiter_if.sv
// Request/grant and bank-pin bundle between the requesters, the bank and dff_bank_arbiter.
// slave: the arbiter side. master: the requesters plus the bank that returns q.
interface dff_bank_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0, req1;
    logic [1:0]       op0, op1;
    logic [WIDTH-1:0] data0, data1;
    logic             gnt0, gnt1;
    logic             done;
    logic             busy;
    logic [WIDTH-1:0] bank_q;
    logic [WIDTH-1:0] bank_d;
    logic [WIDTH-1:0] bank_pre;
    logic [WIDTH-1:0] bank_clr;

    modport slave (
        input  req0, req1, op0, op1, data0, data1, bank_q,
        output gnt0, gnt1, done, busy, bank_d, bank_pre, bank_clr
    );

    modport master (
        output req0, req1, op0, op1, data0, data1, bank_q,
        input  gnt0, gnt1, done, busy, bank_d, bank_pre, bank_clr
    );
endinterface

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter and sequencer for a shared bank of D flip-flops that have
// active-low async preset/clear. One requester at a time runs load, clear,
// preset or toggle on the bank. Between operations the bank holds because q is
// fed back to d.
// Build option: DFFCTL_TOGGLE_EN enables op 11 (toggle). When it is undefined,
// op 11 is a granted no-op that uses load timing.

// Per-bit d-pin select: load data, inverted q, or q fed back.
module dff_bank_arbiter_lane (
    input  logic q,
    input  logic ld,
    input  logic sel_ld,
    input  logic sel_tg,
    output logic d
);
    assign d = sel_ld ? ld : (sel_tg ? ~q : q);
endmodule

module dff_bank_arbiter #(
    parameter int WIDTH = 8,
    parameter int PULSE = 2
) (
    input logic              clk,
    input logic              clr,
    dff_bank_arbiter_if.slave bus
);
    localparam int CW = $clog2(PULSE + 1);
    localparam logic [CW-1:0] CNT_LD = CW'(PULSE - 1);

    localparam logic [1:0] OP_LD  = 2'b00;
    localparam logic [1:0] OP_CLR = 2'b01;
    localparam logic [1:0] OP_PRE = 2'b10;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] data;
    } req_t;

    state_t           state, state_nxt;
    logic             last;
    logic             win;
    logic             any_req;
    req_t             win_req;
    req_t             cur;
    logic [1:0]       op_nxt;
    logic [CW-1:0]    cnt;
    logic             gnt0_r, gnt1_r;
    logic [WIDTH-1:0] pre_r, clr_r;
    logic             sel_ld, sel_tg;
    logic [WIDTH-1:0] d_lane;

    // Arbitration: a lone request always wins. On a tie, the requester not served last wins.
    always_comb begin
        any_req = bus.req0 | bus.req1;
        win     = 1'b0;
        if (bus.req0 && bus.req1) win = ~last;
        else                      win = bus.req1;
        win_req = win ? req_t'{op: bus.op1, data: bus.data1}
                      : req_t'{op: bus.op0, data: bus.data0};
    end

    // State register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state. A count of zero is loaded for load/toggle, so the exit test is the same for every op.
    // op_nxt is the op that will be running after the edge, and it drives the registered pins.
    always_comb begin
        state_nxt = state;
        op_nxt    = cur.op;
        case (state)
            IDLE: begin
                op_nxt = win_req.op;
                if (any_req) state_nxt = EXEC;
            end
            EXEC:    if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered controls: grants, fairness pointer, latched request, pulse counter, async pins.
    // Under reset the clear pin is held low so the bank resets with the controller.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            gnt0_r <= 1'b0;
            gnt1_r <= 1'b0;
            last   <= 1'b1;
            cur    <= '0;
            cnt    <= '0;
            pre_r  <= '1;
            clr_r  <= '0;
        end else begin
            pre_r <= (state_nxt == EXEC && op_nxt == OP_PRE) ? '0 : '1;
            clr_r <= (state_nxt == EXEC && op_nxt == OP_CLR) ? '0 : '1;
            case (state)
                IDLE: if (any_req) begin
                    gnt0_r <= ~win;
                    gnt1_r <= win;
                    last   <= win;
                    cur    <= win_req;
                    cnt    <= (win_req.op == OP_CLR || win_req.op == OP_PRE) ? CNT_LD : '0;
                end
                EXEC: if (cnt != '0) cnt <= cnt - 1'b1;
                DONE: begin
                    gnt0_r <= 1'b0;
                    gnt1_r <= 1'b0;
                end
                default: begin
                    gnt0_r <= 1'b0;
                    gnt1_r <= 1'b0;
                end
            endcase
        end
    end

    // Outputs decoded from state: status flags and the d-pin select for the EXEC cycle.
    always_comb begin
        bus.done = (state == DONE);
        bus.busy = (state != IDLE);
        sel_ld   = (state == EXEC) && (cur.op == OP_LD);
`ifdef DFFCTL_TOGGLE_EN
        sel_tg   = (state == EXEC) && (cur.op == 2'b11);
`else
        sel_tg   = 1'b0;
`endif
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        dff_bank_arbiter_lane u_lane (
            .q      (bus.bank_q[i]),
            .ld     (cur.data[i]),
            .sel_ld (sel_ld),
            .sel_tg (sel_tg),
            .d      (d_lane[i])
        );
    end

    assign bus.bank_d   = d_lane;
    assign bus.bank_pre = pre_r;
    assign bus.bank_clr = clr_r;
    assign bus.gnt0     = gnt0_r;
    assign bus.gnt1     = gnt1_r;
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Bench for dff_bank_arbiter. It models the DFF bank, checks an op table and
// runs hand-written tie, abort and re-request sequences. A scoreboard checks
// every done pulse.
module tb_dff_bank_arbiter;
    localparam logic [1:0] LD = 2'b00, CL = 2'b01, PR = 2'b10, TG = 2'b11;
`ifdef DFFCTL_TOGGLE_EN
    localparam bit TGL_EN = 1'b1;
`else
    localparam bit TGL_EN = 1'b0;
`endif

    typedef struct {
        int         who;
        logic [1:0] op;
        logic [7:0] data;
        logic [7:0] exp_bank;
        int         lat;
        int         clr_cyc;
        int         pre_cyc;
    } vec_t;

    typedef struct {
        int         who;
        logic [7:0] bank;
        int         cyc;
    } sb_t;

    logic clk;
    logic clr;
    int   cyc;
    int   n_vec;
    int   n_err;
    sb_t  sbq[$];
    sb_t  ent;
    logic [7:0] q_r;

    dff_bank_arbiter_if #(.WIDTH(8)) bus ();

    dff_bank_arbiter #(.WIDTH(8), .PULSE(2)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Bank model: a clocked q, with the async clear (stronger) and preset applied on top.
    always @(posedge clk) q_r <= (bus.bank_d | ~bus.bank_pre) & bus.bank_clr;
    assign bus.bank_q = (q_r | ~bus.bank_pre) & bus.bank_clr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive(input int who, input logic [1:0] op, input logic [7:0] d, input logic r);
        if (who == 0) begin bus.req0 = r; bus.op0 = op; bus.data0 = d; end
        else          begin bus.req1 = r; bus.op1 = op; bus.data1 = d; end
    endtask

    task automatic wait_idle();
        bit fin = 1'b0;
        for (int k = 0; k < 20 && !fin; k++) begin
            @(negedge clk);
            if (!bus.busy) fin = 1'b1;
        end
        chk("idle_timeout", 32'(fin), 32'd1);
    endtask

    // Scoreboard: each done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (bus.done) begin
            if (sbq.size() == 0) begin
                chk("done_unexpected", 32'd1, 32'd0);
            end else begin
                ent = sbq.pop_front();
                chk("done_gnt", 32'({bus.gnt1, bus.gnt0}), (ent.who != 0) ? 32'd2 : 32'd1);
                chk("done_bank", 32'(bus.bank_q), 32'(ent.bank));
                chk("done_cycle", 32'(cyc), 32'(ent.cyc));
            end
        end
    end

    initial begin
        vec_t       vt[8];
        logic [1:0] eg[8];
        int c, g, o, b, cc, pc;
        bit fin;

        vt[0] = '{0, LD, 8'hA5, 8'hA5, 1, 0, 0};
        vt[1] = '{1, CL, 8'h00, 8'h00, 2, 2, 0};
        vt[2] = '{1, LD, 8'h0F, 8'h0F, 1, 0, 0};
        vt[3] = '{0, TG, 8'h00, TGL_EN ? 8'hF0 : 8'h0F, 1, 0, 0};
        vt[4] = '{0, PR, 8'h00, 8'hFF, 2, 0, 2};
        vt[5] = '{1, LD, 8'h3C, 8'h3C, 1, 0, 0};
        vt[6] = '{1, TG, 8'h00, TGL_EN ? 8'hC3 : 8'h3C, 1, 0, 0};
        vt[7] = '{0, CL, 8'h00, 8'h00, 2, 2, 0};

        n_vec = 0; n_err = 0; cyc = 0;
        bus.req0 = 0; bus.req1 = 0; bus.op0 = 0; bus.op1 = 0; bus.data0 = 0; bus.data1 = 0;
        clr = 1'b1;
        #2 clr = 1'b0;
        #1;
        chk("rst_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_pre", 32'(bus.bank_pre), 32'hFF);
        chk("rst_clr", 32'(bus.bank_clr), 32'h00);
        chk("rst_bank", 32'(bus.bank_q), 32'h00);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        chk("post_rst_clr", 32'(bus.bank_clr), 32'hFF);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);

        // Op table, one requester at a time.
        foreach (vt[i]) begin
            c = cyc;
            drive(vt[i].who, vt[i].op, vt[i].data, 1'b1);
            sbq.push_back('{vt[i].who, vt[i].exp_bank, c + 1 + vt[i].lat});
            g = 0; o = 0; b = 0; cc = 0; pc = 0; fin = 1'b0;
            for (int k = 0; k < 20 && !fin; k++) begin
                @(negedge clk);
                if ((vt[i].who != 0) ? bus.gnt1 : bus.gnt0) g++;
                if ((vt[i].who != 0) ? bus.gnt0 : bus.gnt1) o++;
                if (bus.busy) b++;
                if (bus.bank_clr == 8'h00) cc++;
                if (bus.bank_pre == 8'h00) pc++;
                if (k == 0) drive(vt[i].who, vt[i].op, vt[i].data, 1'b0);
                if (!bus.busy) fin = 1'b1;
            end
            chk($sformatf("v%0d_timeout", i), 32'(fin), 32'd1);
            chk($sformatf("v%0d_gnt_cyc", i), 32'(g), 32'(vt[i].lat + 1));
            chk($sformatf("v%0d_other_gnt", i), 32'(o), 32'd0);
            chk($sformatf("v%0d_busy_cyc", i), 32'(b), 32'(vt[i].lat + 1));
            chk($sformatf("v%0d_clr_cyc", i), 32'(cc), 32'(vt[i].clr_cyc));
            chk($sformatf("v%0d_pre_cyc", i), 32'(pc), 32'(vt[i].pre_cyc));
            chk($sformatf("v%0d_bank", i), 32'(bus.bank_q), 32'(vt[i].exp_bank));
        end

        // Preset aborted by reset in its first cycle.
        drive(0, PR, 8'h00, 1'b1);
        @(negedge clk);
        chk("abort_pre_on", 32'(bus.bank_pre), 32'h00);
        chk("abort_bank_ff", 32'(bus.bank_q), 32'hFF);
        chk("abort_gnt_on", 32'(bus.gnt0), 32'd1);
        clr = 1'b0;
        drive(0, PR, 8'h00, 1'b0);
        #1;
        chk("abort_pre", 32'(bus.bank_pre), 32'hFF);
        chk("abort_clr", 32'(bus.bank_clr), 32'h00);
        chk("abort_bank", 32'(bus.bank_q), 32'h00);
        chk("abort_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        chk("abort_rel_clr", 32'(bus.bank_clr), 32'hFF);
        chk("abort_rel_bank", 32'(bus.bank_q), 32'h00);

        // Ties after reset: req1 stays high and req0 is raised again, so the grants go 0, 1, 0.
        eg = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01};
        c = cyc;
        drive(0, LD, 8'h11, 1'b1);
        drive(1, LD, 8'h22, 1'b1);
        sbq.push_back('{0, 8'h11, c + 2});
        sbq.push_back('{1, 8'h22, c + 5});
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("tie_gnt_k%0d", k), 32'({bus.gnt1, bus.gnt0}), 32'(eg[k-1]));
            if (k == 1) bus.req0 = 1'b0;
            if (k == 5) begin
                drive(0, LD, 8'h33, 1'b1);
                sbq.push_back('{0, 8'h33, c + 8});
            end
            if (k == 7) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
        end
        wait_idle();

        // req0 held through DONE is granted again. req1 raised while busy is ignored.
        c = cyc;
        drive(0, LD, 8'h5A, 1'b1);
        sbq.push_back('{0, 8'h5A, c + 2});
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("hold_gnt_k%0d", k), 32'({bus.gnt1, bus.gnt0}),
                (k == 3) ? 32'd0 : 32'd1);
            if (k == 1) begin
                drive(1, LD, 8'h77, 1'b1);
                bus.data0 = 8'h96;
            end
            if (k == 2) bus.req1 = 1'b0;
            if (k == 3) sbq.push_back('{0, 8'h96, c + 5});
            if (k == 4) bus.req0 = 1'b0;
        end
        wait_idle();
        @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        chk("final_bank", 32'(bus.bank_q), 32'h96);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
